// File: rtl/pixel_write_arbiter.sv
// Arbitrates the single VGA pixel-write port between three drawing engines and
// registers the granted client's pixel onto the VGA adapter, clipping off-screen writes.
module pixel_write_arbiter #(
  parameter int unsigned XSCREEN  = 640,
  parameter int unsigned YSCREEN  = 480,
  parameter int unsigned MAX_HOLD = 4096,
  parameter int unsigned PRIO0    = 1
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [2:0]  req,
  input  logic [2:0]  lock,
  input  logic [2:0]  wr,
  input  logic [29:0] x_bus,
  input  logic [26:0] y_bus,
  input  logic [26:0] color_bus,
  output logic [2:0]  gnt,
  output logic [9:0]  VGA_x,
  output logic [8:0]  VGA_y,
  output logic [8:0]  VGA_color,
  output logic        VGA_write,
  output logic        busy,
  output logic        clip_err
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        r_state, w_stateNext;
  logic [1:0]    r_owner, r_lastOwner, w_ownerNext, w_lastOwnerNext, w_rrWinner, w_winner;
  logic [HW-1:0] r_holdCnt, w_holdCntNext;
  logic [2:0]    r_gnt, w_gntNext;
  logic          w_othersReq, w_expired, w_leave;

  logic [9:0]    r_vgaX, w_selX;
  logic [8:0]    r_vgaY, r_vgaColor, w_selY, w_selColor;
  logic          r_vgaWrite, r_clipErr, w_wrHit, w_clip;

  function automatic logic [1:0] pickFirst(input logic [2:0] r, input logic [1:0] a,
                                           input logic [1:0] b, input logic [1:0] c);
    if (r[a])      return a;
    else if (r[b]) return b;
    return c;
  endfunction

  always_comb begin
    case (r_lastOwner)
      2'd0:    w_rrWinner = pickFirst(req, 2'd1, 2'd2, 2'd0);
      2'd1:    w_rrWinner = pickFirst(req, 2'd2, 2'd0, 2'd1);
      default: w_rrWinner = pickFirst(req, 2'd0, 2'd1, 2'd2);
    endcase
    w_winner = ((PRIO0 != 0) && req[0]) ? 2'd0 : w_rrWinner;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state     <= IDLE;
      r_owner     <= 2'd0;
      r_lastOwner <= 2'd2;
      r_holdCnt   <= '0;
      r_gnt       <= 3'b000;
    end else begin
      r_state     <= w_stateNext;
      r_owner     <= w_ownerNext;
      r_lastOwner <= w_lastOwnerNext;
      r_holdCnt   <= w_holdCntNext;
      r_gnt       <= w_gntNext;
    end
  end

  // The owner leaves on its own release, or is preempted once its hold budget is spent
  // and someone else is waiting; a held lock overrides both.
  assign w_othersReq = |(req & ~r_gnt);
  assign w_expired   = (r_holdCnt >= HW'(MAX_HOLD - 1));
  assign w_leave     = !lock[r_owner] && (!req[r_owner] || (w_expired && w_othersReq));

  always_comb begin
    w_stateNext     = r_state;
    w_ownerNext     = r_owner;
    w_lastOwnerNext = r_lastOwner;
    w_holdCntNext   = r_holdCnt;
    w_gntNext       = r_gnt;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_gntNext     = 3'b001 << w_winner;
          w_ownerNext   = w_winner;
          w_holdCntNext = '0;
          w_stateNext   = OWNED;
        end
      end
      OWNED: begin
        if (r_holdCnt < HW'(MAX_HOLD)) w_holdCntNext = r_holdCnt + HW'(1);
        if (w_leave) begin
          w_gntNext       = 3'b000;
          w_lastOwnerNext = r_owner;
          w_stateNext     = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == OWNED);
  end

  always_comb begin
    w_wrHit = |(r_gnt & wr);
    case (r_gnt)
      3'b010: begin
        w_selX = x_bus[19:10]; w_selY = y_bus[17:9]; w_selColor = color_bus[17:9];
      end
      3'b100: begin
        w_selX = x_bus[29:20]; w_selY = y_bus[26:18]; w_selColor = color_bus[26:18];
      end
      default: begin
        w_selX = x_bus[9:0]; w_selY = y_bus[8:0]; w_selColor = color_bus[8:0];
      end
    endcase
    w_clip = (32'(w_selX) >= XSCREEN) || (32'(w_selY) >= YSCREEN);
  end

  // Coordinates are captured even on a clipped write; only the strobe is suppressed.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_vgaX     <= '0;
      r_vgaY     <= '0;
      r_vgaColor <= '0;
      r_vgaWrite <= 1'b0;
      r_clipErr  <= 1'b0;
    end else begin
      r_vgaWrite <= 1'b0;
      if (w_wrHit) begin
        r_vgaX     <= w_selX;
        r_vgaY     <= w_selY;
        r_vgaColor <= w_selColor;
        if (w_clip) r_clipErr  <= 1'b1;
        else        r_vgaWrite <= 1'b1;
      end
    end
  end

  assign gnt       = r_gnt;
  assign VGA_x     = r_vgaX;
  assign VGA_y     = r_vgaY;
  assign VGA_color = r_vgaColor;
  assign VGA_write = r_vgaWrite;
  assign clip_err  = r_clipErr;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench: a round-robin instance (PRIO0=0) and a priority instance (PRIO0=1)
// share the same stimulus, both with MAX_HOLD=8.
module tb_pixel_write_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [2:0]  req, lock, wr;
  logic [29:0] x_bus;
  logic [26:0] y_bus, color_bus;

  logic [2:0]  gnt, gntP;
  logic [9:0]  VGA_x, VGA_xP;
  logic [8:0]  VGA_y, VGA_yP, VGA_color, VGA_colorP;
  logic        VGA_write, VGA_writeP, busy, busyP, clip_err, clip_errP;

  int checks = 0;
  int errors = 0;

  pixel_write_arbiter #(.XSCREEN(640), .YSCREEN(480), .MAX_HOLD(8), .PRIO0(0)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .lock(lock), .wr(wr),
    .x_bus(x_bus), .y_bus(y_bus), .color_bus(color_bus),
    .gnt(gnt), .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color),
    .VGA_write(VGA_write), .busy(busy), .clip_err(clip_err));

  pixel_write_arbiter #(.XSCREEN(640), .YSCREEN(480), .MAX_HOLD(8), .PRIO0(1)) dutP (
    .Clock(Clock), .Resetn(Resetn), .req(req), .lock(lock), .wr(wr),
    .x_bus(x_bus), .y_bus(y_bus), .color_bus(color_bus),
    .gnt(gntP), .VGA_x(VGA_xP), .VGA_y(VGA_yP), .VGA_color(VGA_colorP),
    .VGA_write(VGA_writeP), .busy(busyP), .clip_err(clip_errP));

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic setPix(input int i, input logic [9:0] x, input logic [8:0] y, input logic [8:0] c);
    x_bus[10*i +: 10]    = x;
    y_bus[9*i +: 9]      = y;
    color_bus[9*i +: 9]  = c;
  endtask

  task automatic doReset();
    Resetn = 1'b0; req = '0; lock = '0; wr = '0;
    x_bus = '0; y_bus = '0; color_bus = '0;
    step(); step();
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (VGA_write !== 1'b0 || VGA_x !== 10'd0 || VGA_y !== 9'd0 || VGA_color !== 9'd0) begin
      errors++; $display("[TB] FAIL reset_vga: got w=%b x=%0d y=%0d c=%h expected all 0", VGA_write, VGA_x, VGA_y, VGA_color); end
    checks++; if (busy !== 1'b0 || clip_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got busy=%b clip=%b expected 0 0", busy, clip_err); end
  endtask

  task automatic test_single();
    doReset();
    req = 3'b010;
    step();
    checks++; if (gnt !== 3'b010 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL single_gnt: got gnt=%b busy=%b expected 010 1", gnt, busy); end
    wr = 3'b010; setPix(1, 10'd100, 9'd200, 9'h1C7);
    step();
    checks++; if (VGA_write !== 1'b1 || VGA_x !== 10'd100 || VGA_y !== 9'd200 || VGA_color !== 9'h1C7) begin
      errors++; $display("[TB] FAIL single_write: got w=%b x=%0d y=%0d c=%h expected 1 100 200 1c7", VGA_write, VGA_x, VGA_y, VGA_color); end
    wr = 3'b000;
    step();
    checks++; if (VGA_write !== 1'b0 || VGA_x !== 10'd100) begin
      errors++; $display("[TB] FAIL single_hold: got w=%b x=%0d expected 0 100", VGA_write, VGA_x); end
    req = 3'b000;
    step();
    checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL single_release: got gnt=%b busy=%b expected 000 0", gnt, busy); end
  endtask

  task automatic test_round_robin();
    int order [4];
    logic [2:0] exp;
    order = '{0, 1, 2, 0};
    doReset();
    req = 3'b111;
    step();
    for (int k = 0; k < 4; k++) begin
      exp = 3'b001 << order[k];
      checks++; if (gnt !== exp) begin
        errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, gnt, exp); end
      for (int j = 0; j < 5; j++) begin
        wr = exp;
        setPix(order[k], 10'(10 * k + j), 9'(j + 1), 9'(k));
        step();
        checks++; if (VGA_write !== 1'b1 || VGA_x !== 10'(10 * k + j) || VGA_y !== 9'(j + 1)) begin
          errors++; $display("[TB] FAIL rr_write%0d_%0d: got w=%b x=%0d y=%0d expected 1 %0d %0d",
                             k, j, VGA_write, VGA_x, VGA_y, 10 * k + j, j + 1); end
      end
      wr = 3'b000;
      req[order[k]] = 1'b0;
      step();
      checks++; if (gnt !== 3'b000) begin
        errors++; $display("[TB] FAIL rr_dead%0d: got %b expected 000", k, gnt); end
      req[order[k]] = 1'b1;
      step();
    end
    req = 3'b000;
  endtask

  task automatic test_priority();
    // Client 1 releases with 0 and 2 waiting: round-robin picks 2, priority picks 0.
    doReset();
    req = 3'b010;
    step();
    req = 3'b111;
    step();
    req = 3'b101;
    step();
    checks++; if (gnt !== 3'b000) begin
      errors++; $display("[TB] FAIL prio_dead: got %b expected 000", gnt); end
    step();
    checks++; if (gntP !== 3'b001) begin
      errors++; $display("[TB] FAIL prio_winner0: got %b expected 001", gntP); end
    checks++; if (gnt !== 3'b100) begin
      errors++; $display("[TB] FAIL rr_winner2: got %b expected 100", gnt); end
    doReset();
    req = 3'b100;
    step();
    checks++; if (gntP !== 3'b100) begin
      errors++; $display("[TB] FAIL prio_owner2: got %b expected 100", gntP); end
    req = 3'b111;
    step();
    req = 3'b011;
    step();
    step();
    checks++; if (gntP !== 3'b001) begin
      errors++; $display("[TB] FAIL prio_after2: got %b expected 001", gntP); end
    req = 3'b000;
  endtask

  task automatic test_preempt();
    int cnt;
    int bad;
    doReset();
    req = 3'b010;
    step();
    cnt = (gnt == 3'b010) ? 1 : 0;
    req = 3'b110;
    for (int n = 0; n < 20; n++) begin
      step();
      if (gnt == 3'b010) cnt++;
      else break;
    end
    checks++; if (cnt !== 8) begin
      errors++; $display("[TB] FAIL preempt_len: got %0d cycles expected 8", cnt); end
    checks++; if (gnt !== 3'b000) begin
      errors++; $display("[TB] FAIL preempt_dead: got %b expected 000", gnt); end
    step();
    checks++; if (gnt !== 3'b100) begin
      errors++; $display("[TB] FAIL preempt_next: got %b expected 100", gnt); end

    doReset();
    req = 3'b010; lock = 3'b010;
    step();
    req = 3'b110;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (gnt !== 3'b010) bad++;
    end
    checks++; if (bad !== 0) begin
      errors++; $display("[TB] FAIL lock_hold: got %0d lost cycles expected 0", bad); end
    lock = 3'b000;
    step();
    checks++; if (gnt !== 3'b000) begin
      errors++; $display("[TB] FAIL unlock_preempt: got %b expected 000", gnt); end
    req = 3'b000;
  endtask

  task automatic test_clip();
    doReset();
    req = 3'b001;
    step();
    wr = 3'b001; setPix(0, 10'd640, 9'd10, 9'h0AA);
    step();
    checks++; if (VGA_write !== 1'b0 || clip_err !== 1'b1) begin
      errors++; $display("[TB] FAIL clip_x: got w=%b clip=%b expected 0 1", VGA_write, clip_err); end
    setPix(0, 10'd639, 9'd479, 9'h155);
    step();
    checks++; if (VGA_write !== 1'b1 || VGA_x !== 10'd639 || VGA_y !== 9'd479 || VGA_color !== 9'h155) begin
      errors++; $display("[TB] FAIL clip_edge: got w=%b x=%0d y=%0d c=%h expected 1 639 479 155", VGA_write, VGA_x, VGA_y, VGA_color); end
    checks++; if (clip_err !== 1'b1) begin
      errors++; $display("[TB] FAIL clip_sticky: got %b expected 1", clip_err); end
    setPix(0, 10'd5, 9'd480, 9'h001);
    step();
    checks++; if (VGA_write !== 1'b0) begin
      errors++; $display("[TB] FAIL clip_y: got w=%b expected 0", VGA_write); end
    wr = 3'b000;
    req = 3'b000;
    step();
  endtask

  task automatic test_rogue_reset();
    doReset();
    checks++; if (clip_err !== 1'b0) begin
      errors++; $display("[TB] FAIL clip_cleared: got %b expected 0", clip_err); end
    req = 3'b001;
    step();
    wr = 3'b011;
    setPix(0, 10'd7, 9'd8, 9'h009);
    setPix(1, 10'd33, 9'd44, 9'h055);
    step();
    checks++; if (VGA_write !== 1'b1 || VGA_x !== 10'd7 || VGA_y !== 9'd8) begin
      errors++; $display("[TB] FAIL rogue_mixed: got w=%b x=%0d y=%0d expected 1 7 8", VGA_write, VGA_x, VGA_y); end
    wr = 3'b010;
    step();
    checks++; if (VGA_write !== 1'b0 || VGA_x !== 10'd7) begin
      errors++; $display("[TB] FAIL rogue_only: got w=%b x=%0d expected 0 7", VGA_write, VGA_x); end
    wr = 3'b001;
    setPix(0, 10'd20, 9'd21, 9'h022);
    step();
    checks++; if (VGA_write !== 1'b1 || VGA_x !== 10'd20) begin
      errors++; $display("[TB] FAIL burst_write: got w=%b x=%0d expected 1 20", VGA_write, VGA_x); end
    Resetn = 1'b0;
    step();
    checks++; if (gnt !== 3'b000 || VGA_write !== 1'b0 || VGA_x !== 10'd0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midgrant_reset: got gnt=%b w=%b x=%0d busy=%b expected 000 0 0 0", gnt, VGA_write, VGA_x, busy); end
    Resetn = 1'b1;
    wr = 3'b000;
    req = 3'b000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_preempt();
    test_clip();
    test_rogue_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
